// File: rtl/log_capture_ctrl_if.sv
// Control, status and RAM-port bundle of log_capture_ctrl.
// master drives the requests; slave (the controller) drives the RAM port and status.
interface log_capture_ctrl_if #(
  parameter int unsigned RAM_DEPTH = 32768,
  parameter int unsigned NBT_DECIM = 8
);
  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic                 i_arm;
  logic                 i_abort;
  logic                 i_trigger;
  logic                 i_sample_en;
  logic [NBT_DECIM-1:0] i_decim;
  logic                 i_rd_req;
  logic [AW-1:0]        i_rd_adrs;

  logic                 o_en_write;
  logic [AW-1:0]        o_wr_adrs;
  logic                 o_en_read;
  logic [AW-1:0]        o_rd_adrs;
  logic                 o_rd_valid;
  logic                 o_rd_err;
  logic [2:0]           o_state;
  logic                 o_done;
  logic                 o_timeout;

  modport master (
    output i_arm, i_abort, i_trigger, i_sample_en, i_decim, i_rd_req, i_rd_adrs,
    input  o_en_write, o_wr_adrs, o_en_read, o_rd_adrs, o_rd_valid, o_rd_err,
           o_state, o_done, o_timeout
  );

  modport slave (
    input  i_arm, i_abort, i_trigger, i_sample_en, i_decim, i_rd_req, i_rd_adrs,
    output o_en_write, o_wr_adrs, o_en_read, o_rd_adrs, o_rd_valid, o_rd_err,
           o_state, o_done, o_timeout
  );
endinterface

// File: rtl/log_capture_ctrl.sv
// Log RAM capture controller: arm, wait for trigger, skip N_DELAY strobes, then write
// decimated samples until the RAM is full. Optional trigger timeout: LOG_CAPTURE_CTRL_TRIG_TIMEOUT_EN.
module log_capture_ctrl #(
  parameter int unsigned RAM_DEPTH   = 32768,
  parameter int unsigned N_DELAY     = 500,
  parameter int unsigned NBT_DECIM   = 8,
  parameter int unsigned NBT_TIMEOUT = 24
) (
  input  logic              clk,
  input  logic              i_reset,
  log_capture_ctrl_if.slave bus
);

  localparam int unsigned   AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned   DW        = (N_DELAY > 1) ? $clog2(N_DELAY) : 1;
  localparam logic [AW-1:0] LAST_ADRS = AW'(RAM_DEPTH - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'((N_DELAY > 0) ? N_DELAY - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e               state_q,    state_d;
  logic [DW-1:0]        dly_q,      dly_d;
  logic [NBT_DECIM-1:0] dec_q,      dec_d;
  logic [NBT_DECIM-1:0] decim_q,    decim_d;
  logic [AW-1:0]        wr_adrs_q,  wr_adrs_d;
  logic [AW-1:0]        rd_adrs_q,  rd_adrs_d;
  logic                 en_write_q, en_write_d;
  logic                 en_read_q,  en_read_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_err_q,   rd_err_d;
  logic                 done_q,     done_d;
  logic                 busy;
  logic                 arm_go;
  logic                 to_fire;

  assign busy   = (state_q == ST_ARMED) || (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
  assign arm_go = bus.i_arm && !bus.i_abort && !busy;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    dec_d      = dec_q;
    decim_d    = decim_q;
    wr_adrs_d  = wr_adrs_q;
    en_write_d = 1'b0;
    done_d     = done_q;
    en_read_d  = 1'b0;
    rd_adrs_d  = rd_adrs_q;
    rd_valid_d = en_read_q;
    rd_err_d   = 1'b0;

    // Address advances the cycle after each write and parks on the last entry.
    if (en_write_q && (wr_adrs_q != LAST_ADRS)) begin
      wr_adrs_d = wr_adrs_q + AW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arm_go) begin
          state_d   = ST_ARMED;
          wr_adrs_d = '0;
        end
      end
      ST_ARMED: begin
        if (bus.i_abort) begin
          state_d = ST_IDLE;
        end else if (bus.i_trigger || to_fire) begin
          if (N_DELAY == 0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_DELAY;
            dly_d   = '0;
          end
        end
      end
      ST_DELAY: begin
        if (bus.i_abort) begin
          state_d = ST_IDLE;
        end else if (bus.i_sample_en) begin
          if (dly_q == DLY_LAST) begin
            state_d = ST_CAPTURE;
          end else begin
            dly_d = dly_q + DW'(1);
          end
        end
      end
      ST_CAPTURE: begin
        if (bus.i_abort) begin
          state_d = ST_IDLE;
        end else if (bus.i_sample_en) begin
          if (dec_q == '0) begin
            en_write_d = 1'b1;
            dec_d      = decim_q;
            // wr_adrs_d already holds the address this write lands on.
            if (wr_adrs_d == LAST_ADRS) begin
              state_d = ST_DONE;
            end
          end else begin
            dec_d = dec_q - NBT_DECIM'(1);
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (arm_go) begin
          state_d   = ST_ARMED;
          done_d    = 1'b0;
          wr_adrs_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Decimation ratio is frozen at capture entry.
    if ((state_d == ST_CAPTURE) && (state_q != ST_CAPTURE)) begin
      dec_d   = bus.i_decim;
      decim_d = bus.i_decim;
    end

    // RAM port is owned by the capture while busy, so reads are refused then.
    if (bus.i_rd_req) begin
      if (busy) begin
        rd_err_d = 1'b1;
      end else begin
        en_read_d = 1'b1;
        rd_adrs_d = bus.i_rd_adrs;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      dly_q      <= '0;
      dec_q      <= '0;
      decim_q    <= '0;
      wr_adrs_q  <= '0;
      rd_adrs_q  <= '0;
      en_write_q <= 1'b0;
      en_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      dec_q      <= dec_d;
      decim_q    <= decim_d;
      wr_adrs_q  <= wr_adrs_d;
      rd_adrs_q  <= rd_adrs_d;
      en_write_q <= en_write_d;
      en_read_q  <= en_read_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      done_q     <= done_d;
    end
  end

`ifdef LOG_CAPTURE_CTRL_TRIG_TIMEOUT_EN
  // Counter value on the last of 2^NBT_TIMEOUT-1 trigger-less ARMED cycles.
  localparam logic [NBT_TIMEOUT-1:0] TO_LAST = {{(NBT_TIMEOUT-1){1'b1}}, 1'b0};

  logic [NBT_TIMEOUT-1:0] to_cnt_q, to_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   armed_wait;

  assign armed_wait = (state_q == ST_ARMED) && !bus.i_abort && !bus.i_trigger;
  assign to_fire    = armed_wait && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    if (armed_wait && !to_fire) begin
      to_cnt_d = to_cnt_q + NBT_TIMEOUT'(1);
    end
    if (to_fire) begin
      timeout_d = 1'b1;
    end
    if (arm_go) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign to_fire       = 1'b0;
  assign bus.o_timeout = 1'b0;

  if (NBT_TIMEOUT == 0) begin : g_no_timeout_width
  end
`endif

  assign bus.o_en_write = en_write_q;
  assign bus.o_wr_adrs  = wr_adrs_q;
  assign bus.o_en_read  = en_read_q;
  assign bus.o_rd_adrs  = rd_adrs_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_err   = rd_err_q;
  assign bus.o_state    = state_q;
  assign bus.o_done     = done_q;

endmodule

// File: doc/log_capture_ctrl.md
LOG_CAPTURE_CTRL -- requirements
Module: log_capture_ctrl

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 32768, number of log RAM entries (power of two).
REQ-002 SHALL have parameter N_DELAY, default 500, post-trigger samples skipped before capture.
REQ-003 SHALL have parameter NBT_DECIM, default 8, width of the decimation field.
REQ-004 SHALL have parameter NBT_TIMEOUT, default 24, width of the trigger-timeout counter.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_arm, input, 1 bit: one-cycle arm request.
REQ-008 SHALL have port i_abort, input, 1 bit: one-cycle abort request.
REQ-009 SHALL have port i_trigger, input, 1 bit: level trigger, e.g. sync done.
REQ-010 SHALL have port i_sample_en, input, 1 bit: datapath sample strobe, e.g. rate control.
REQ-011 SHALL have port i_decim, input, NBT_DECIM bits: write one sample every i_decim+1 strobes.
REQ-012 SHALL have port i_rd_req, input, 1 bit: register-file read request.
REQ-013 SHALL have port i_rd_adrs, input, log2(RAM_DEPTH) bits: requested read address.
REQ-014 SHALL have port o_en_write, output, 1 bit: RAM write enable.
REQ-015 SHALL have port o_wr_adrs, output, log2(RAM_DEPTH) bits: RAM write address.
REQ-016 SHALL have port o_en_read, output, 1 bit: RAM read enable.
REQ-017 SHALL have port o_rd_adrs, output, log2(RAM_DEPTH) bits: registered read address.
REQ-018 SHALL have port o_rd_valid, output, 1 bit: read data valid.
REQ-019 SHALL have port o_rd_err, output, 1 bit: read refused.
REQ-020 SHALL have port o_state, output, 3 bits: state code.
REQ-021 SHALL have port o_done, output, 1 bit: capture complete (level).
REQ-022 SHALL have port o_timeout, output, 1 bit: sticky timeout flag.

Function
REQ-023 SHALL implement states IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4; o_state SHALL show the current code.
REQ-024 SHALL go IDLE->ARMED on i_arm; i_arm in DONE SHALL also go to ARMED, clear o_done and o_timeout, and zero o_wr_adrs; i_arm in other states SHALL be ignored.
REQ-025 SHALL go ARMED->DELAY on the first cycle i_trigger=1; with N_DELAY=0 it SHALL go ARMED->CAPTURE.
REQ-026 SHALL, in DELAY, count i_sample_en strobes and enter CAPTURE on the cycle the N_DELAY-th strobe arrives.
REQ-027 SHALL, in CAPTURE, run a decimation counter on i_sample_en strobes, sampling i_decim at CAPTURE entry.
REQ-028 SHALL assert o_en_write for one cycle on the strobe where the decimation counter is 0; the counter SHALL then reload i_decim.
REQ-029 SHALL increment o_wr_adrs after each write, starting at 0.
REQ-030 SHALL, on the write at address RAM_DEPTH-1, go to DONE with no wrap and set o_done next cycle.
REQ-031 SHALL, on i_abort in ARMED, DELAY or CAPTURE, go to IDLE next cycle, deassert o_en_write that cycle, and leave o_done=0.
REQ-032 SHALL give i_abort priority over i_arm and over the trigger and strobes in the same cycle.
REQ-033 SHALL grant reads only in IDLE or DONE: o_en_read=1 and o_rd_adrs=i_rd_adrs one cycle after i_rd_req, and o_rd_valid=1 two cycles after i_rd_req.
REQ-034 SHALL, on i_rd_req in ARMED, DELAY or CAPTURE, keep o_en_read=0 and pulse o_rd_err for one cycle, one cycle after the request.
REQ-035 SHALL never assert o_en_write and o_en_read in the same cycle.

Reset
REQ-036 SHALL, while i_reset=0, immediately force state IDLE, all counters 0, and all outputs 0.
REQ-037 SHALL let reset during CAPTURE discard the capture without a done indication.

Configuration
REQ-038 SHALL, with LOG_CAPTURE_CTRL_TRIG_TIMEOUT_EN defined, count cycles in ARMED; after 2^NBT_TIMEOUT-1 cycles with no trigger it SHALL force entry to DELAY and set o_timeout until the next arm or reset.
REQ-039 SHALL, without LOG_CAPTURE_CTRL_TRIG_TIMEOUT_EN, wait in ARMED indefinitely, tie o_timeout to 0, and contain no timeout counter.

Verification
REQ-040 SHALL cover: N_DELAY=4, RAM_DEPTH=16, i_decim=0, strobe every cycle, arm then trigger -> first o_en_write 4 strobes after trigger, 16 writes at addresses 0..15, o_done=1, state=4.
REQ-041 SHALL cover: i_decim=2 -> o_en_write on every third strobe; no strobe -> no write.
REQ-042 SHALL cover: i_rd_req during CAPTURE -> o_rd_err pulse, o_en_read=0; i_rd_req with adrs 7 in DONE -> o_rd_adrs=7, o_rd_valid two cycles later.
REQ-043 SHALL cover: i_abort with i_arm in the same cycle during CAPTURE -> IDLE, o_done=0; a later re-arm starts at o_wr_adrs=0.
REQ-044 SHALL cover: i_reset low mid-CAPTURE, asynchronous to clk -> all outputs 0 before the next edge.
REQ-045 SHALL cover: timeout build with NBT_TIMEOUT=4 and no trigger -> DELAY after 15 ARMED cycles and o_timeout=1; non-timeout build -> stays ARMED.
